product_accumulator: RTL and testbench

Downstream consumer of the pipelined array multiplier. Sums a programmed number of unsigned products arriving on the multiplier's product/valid outputs into a wide accumulator, then presents the sum through a valid/ready handshake. While the result waits, it raises a stall that the top level uses to gate the multiplier's clock enable. The result is a multiply-accumulate datapath with no change to the multiplier itself.

---
 rtl/product_accumulator.sv | 95 +++++++++
 tb/tb_product_accumulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums a programmed number of multiplier products
// into a wide accumulator and holds the sum behind a valid/ready handshake.
module product_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 8,
  parameter int SATURATE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clk_en_i,
  input  logic                    start_i,
  input  logic [LEN_WIDTH-1:0]    length_i,
  input  logic [2*DATA_WIDTH-1:0] product_i,
  input  logic                    product_valid_i,
  input  logic                    result_ready_i,
  output logic [ACC_WIDTH-1:0]    result_o,
  output logic                    result_valid_o,
  output logic                    overflow_o,
  output logic                    busy_o,
  output logic                    stall_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic [LEN_WIDTH-1:0] rem_q;

  logic [ACC_WIDTH:0]   prod_ext;
  logic [ACC_WIDTH:0]   sum_full;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_d;

  // One extra bit on the adder captures the carry out of ACC_WIDTH.
  always_comb begin
    prod_ext                   = '0;
    prod_ext[2*DATA_WIDTH-1:0] = product_i;
    sum_full                   = {1'b0, acc_q} + prod_ext;
    ovf_d                      = ovf_q | sum_full[ACC_WIDTH];
    acc_d                      = sum_full[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && ovf_d) begin
      acc_d = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else if (clk_en_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= length_i;
            state_q <= (length_i != '0) ? ACCUM : HOLD;
          end
        end
        ACCUM: begin
          if (product_valid_i) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (result_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall depends only on the registered state and ready, never on product inputs.
  assign result_o       = acc_q;
  assign overflow_o     = ovf_q;
  assign result_valid_o = (state_q == HOLD);
  assign busy_o         = (state_q != IDLE);
  assign stall_o        = (state_q == HOLD) & ~result_ready_i;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default 40-bit instance plus two
// 32-bit instances (wrap and saturate) sharing the same stimulus.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        start;
  logic [7:0]  length;
  logic [31:0] product;
  logic        product_valid;
  logic        result_ready;

  logic [39:0] result;
  logic        result_valid, overflow, busy, stall;
  logic [31:0] result_w, result_s;
  logic        valid_w, ovf_w, busy_w, stall_w;
  logic        valid_s, ovf_s, busy_s, stall_s;

  int vectors;
  int miscompares;

  product_accumulator u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .start_i(start),
    .length_i(length), .product_i(product), .product_valid_i(product_valid),
    .result_ready_i(result_ready), .result_o(result), .result_valid_o(result_valid),
    .overflow_o(overflow), .busy_o(busy), .stall_o(stall)
  );

  product_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .start_i(start),
    .length_i(length), .product_i(product), .product_valid_i(product_valid),
    .result_ready_i(result_ready), .result_o(result_w), .result_valid_o(valid_w),
    .overflow_o(ovf_w), .busy_o(busy_w), .stall_o(stall_w)
  );

  product_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .start_i(start),
    .length_i(length), .product_i(product), .product_valid_i(product_valid),
    .result_ready_i(result_ready), .result_o(result_s), .result_valid_o(valid_s),
    .overflow_o(ovf_s), .busy_o(busy_s), .stall_o(stall_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; length = '0;
    product = '0; product_valid = 1'b0; result_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if ({result, result_valid, overflow, busy, stall} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got res=%h v=%b o=%b b=%b s=%b, want all zero",
               result, result_valid, overflow, busy, stall);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start = 1'b1; length = 8'd3; product_valid = 1'b1; product = 32'd100;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || result !== 40'h0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_start: got busy=%b res=%h v=%b, want busy=1 res=0 v=0",
               busy, result, result_valid);
    end
    product = 32'd6;        tick();
    product = 32'd20;       tick();
    product = 32'hFFFE0001; tick();
    product_valid = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || result !== 40'h00FFFE001B || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_sum: got v=%b res=%h ovf=%b, want v=1 res=00fffe001b ovf=0",
               result_valid, result, overflow);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 40'h00FFFE001B) begin
      miscompares++;
      $display("FAIL basic_handshake: got v=%b busy=%b res=%h, want v=0 busy=0 res=00fffe001b",
               result_valid, busy, result);
    end
  endtask

  task automatic test_stall();
    start = 1'b1; length = 8'd2;
    tick();
    start = 1'b0; product_valid = 1'b1;
    product = 32'd5; tick();
    product = 32'd7; tick();
    product = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      length = 8'd9;
      #1;
      vectors++;
      if (stall !== 1'b1 || result !== 40'd12 || result_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got stall=%b res=%h v=%b, want stall=1 res=c v=1",
                 i, stall, result, result_valid);
      end
      tick();
    end
    start = 1'b0;
    result_ready = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drop: got stall=%b, want 0", stall);
    end
    tick();
    result_ready = 1'b0; product_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 40'd12) begin
      miscompares++;
      $display("FAIL stall_release: got busy=%b v=%b res=%h, want busy=0 v=0 res=c",
               busy, result_valid, result);
    end
  endtask

  task automatic test_overflow();
    start = 1'b1; length = 8'd2;
    tick();
    start = 1'b0; product_valid = 1'b1; product = 32'hFFFFFFFF;
    tick();
    tick();
    product_valid = 1'b0;
    vectors++;
    if (result !== 40'h01FFFFFFFE || overflow !== 1'b0 || result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_wide: got res=%h ovf=%b v=%b, want res=01fffffffe ovf=0 v=1",
               result, overflow, result_valid);
    end
    vectors++;
    if (result_w !== 32'hFFFFFFFE || ovf_w !== 1'b1 || valid_w !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_wrap: got res=%h ovf=%b v=%b, want res=fffffffe ovf=1 v=1",
               result_w, ovf_w, valid_w);
    end
    vectors++;
    if (result_s !== 32'hFFFFFFFF || ovf_s !== 1'b1 || valid_s !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sat: got res=%h ovf=%b v=%b, want res=ffffffff ovf=1 v=1",
               result_s, ovf_s, valid_s);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_zero_length();
    start = 1'b1; length = 8'd0;
    tick();
    start = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || result !== 40'h0 || overflow !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_len: got v=%b res=%h ovf=%b busy=%b, want v=1 res=0 ovf=0 busy=1",
               result_valid, result, overflow, busy);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    start = 1'b1; length = 8'd2;
    tick();
    length = 8'd5; product_valid = 1'b1; product = 32'd3;
    tick();
    product = 32'd4;
    tick();
    start = 1'b0; product_valid = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || result !== 40'd7) begin
      miscompares++;
      $display("FAIL start_in_accum: got v=%b res=%h, want v=1 res=7", result_valid, result);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; length = 8'd4;
    tick();
    start = 1'b0; product_valid = 1'b1;
    product = 32'd10; tick();
    product = 32'd20; tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({result, result_valid, overflow, busy, stall} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_mid_accum: got res=%h v=%b o=%b b=%b s=%b, want all zero",
               result, result_valid, overflow, busy, stall);
    end
    tick();
    rst_n = 1'b1;
    product = 32'd50;
    tick(); tick(); tick();
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_ignore_valid: got busy=%b v=%b res=%h, want busy=0 v=0 res=0",
               busy, result_valid, result);
    end
    start = 1'b1; length = 8'd1; product = 32'd99;
    tick();
    start = 1'b0; product = 32'd9;
    tick();
    product_valid = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || result !== 40'd9) begin
      miscompares++;
      $display("FAIL reset_fresh_sum: got v=%b res=%h, want v=1 res=9", result_valid, result);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_clk_en();
    start = 1'b1; length = 8'd3;
    tick();
    start = 1'b0; product_valid = 1'b1; product = 32'd100;
    tick();
    clk_en = 1'b0; product = 32'd1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b1 || result_valid !== 1'b0 || result !== 40'd100) begin
        miscompares++;
        $display("FAIL clken_freeze[%0d]: got busy=%b v=%b res=%h, want busy=1 v=0 res=64",
                 i, busy, result_valid, result);
      end
    end
    clk_en = 1'b1;
    product = 32'd200; tick();
    product = 32'd300; tick();
    product_valid = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || result !== 40'd600) begin
      miscompares++;
      $display("FAIL clken_resume: got v=%b res=%h, want v=1 res=258", result_valid, result);
    end
    clk_en = 1'b0; result_ready = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL clken_stall_hi: got stall=%b, want 1", stall);
    end
    result_ready = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL clken_stall_lo: got stall=%b, want 0", stall);
    end
    tick();
    vectors++;
    if (result_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clken_hold: got v=%b busy=%b, want v=1 busy=1", result_valid, busy);
    end
    clk_en = 1'b1;
    tick();
    result_ready = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clken_release: got v=%b busy=%b, want v=0 busy=0", result_valid, busy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_zero_length();
    test_reset_mid();
    test_clk_en();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
